// File: rtl/noc_pkg.sv
// Shared definitions for the buffered mesh router: port indices, packet field
// offsets and the dimension-ordered route function.
package noc_pkg;

    localparam int unsigned NUM_PORTS = 5;

    typedef enum logic [2:0] {
        PORT_PE = 3'd0,
        PORT_N  = 3'd1,
        PORT_E  = 3'd2,
        PORT_S  = 3'd3,
        PORT_W  = 3'd4
    } port_e;

    // dst_y always starts at bit 0; the other fields follow at multiples of the
    // coordinate widths, so their offsets are derived where the widths are known.
    localparam int unsigned DST_Y_LSB = 0;

    function automatic int unsigned dst_x_lsb(input int unsigned y_size);
        return y_size;
    endfunction

    function automatic int unsigned payload_lsb(input int unsigned x_size, input int unsigned y_size);
        return 2 * (x_size + y_size);
    endfunction

    // X first, then Y; all comparisons unsigned.
    function automatic port_e xy_route(input logic [31:0] dst_x, input logic [31:0] dst_y,
                                       input logic [31:0] x_coord, input logic [31:0] y_coord);
        if (dst_x > x_coord) return PORT_E;
        if (dst_x < x_coord) return PORT_W;
        if (dst_y > y_coord) return PORT_N;
        if (dst_y < y_coord) return PORT_S;
        return PORT_PE;
    endfunction

    function automatic logic [2:0] rr_index(input logic [2:0] base, input int unsigned step);
        return 3'((32'(base) + step) % NUM_PORTS);
    endfunction

endpackage

// File: rtl/noc_input_fifo.sv
// Per-input packet FIFO; a push into a full FIFO is refused even when the
// head is popped in the same cycle.
module noc_input_fifo
    import noc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_router_buffered.sv
// Five-port XY mesh router: input FIFOs, per-output round-robin arbiters and
// one output register per port with valid/ready handshake.
module noc_router_buffered
    import noc_pkg::*;
#(
    parameter int unsigned X_COORD     = 0,
    parameter int unsigned Y_COORD     = 0,
    parameter int unsigned X_SIZE      = 2,
    parameter int unsigned Y_SIZE      = 2,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TOTAL_WIDTH = 2*X_SIZE + 2*Y_SIZE + DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           i_valid,
    output logic [NUM_PORTS-1:0]           o_ready,
    input  logic [NUM_PORTS*TOTAL_WIDTH-1:0] i_data,
    output logic [NUM_PORTS-1:0]           o_valid,
    input  logic [NUM_PORTS-1:0]           i_ready,
    output logic [NUM_PORTS*TOTAL_WIDTH-1:0] o_data,
    output logic                           o_route_err
);

    localparam int unsigned DST_X_LSB = dst_x_lsb(Y_SIZE);

    logic [TOTAL_WIDTH-1:0] head [NUM_PORTS];
    logic [NUM_PORTS-1:0]   full;
    logic [NUM_PORTS-1:0]   empty;
    logic [NUM_PORTS-1:0]   push;
    logic [NUM_PORTS-1:0]   pop;
    logic [NUM_PORTS-1:0]   uturn;
    logic [NUM_PORTS-1:0]   load_en;
    logic [NUM_PORTS-1:0]   grant_v;
    logic [2:0]             grant_idx [NUM_PORTS];
    logic [2:0]             rr_ptr [NUM_PORTS];
    port_e                  route [NUM_PORTS];

    assign o_ready = ~full & {NUM_PORTS{~rst}};
    assign push    = i_valid & o_ready;
    assign load_en = ~o_valid | i_ready;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        noc_input_fifo #(
            .WIDTH (TOTAL_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[p]),
            .pop   (pop[p]),
            .din   (i_data[p*TOTAL_WIDTH +: TOTAL_WIDTH]),
            .head  (head[p]),
            .full  (full[p]),
            .empty (empty[p])
        );
    end

    always_comb begin
        uturn = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            route[p] = xy_route(32'(head[p][DST_X_LSB +: X_SIZE]),
                                32'(head[p][DST_Y_LSB +: Y_SIZE]),
                                32'(X_COORD), 32'(Y_COORD));
            uturn[p] = ~empty[p] && (p != 0) && (route[p] == port_e'(p));
        end
    end

    // Heads requesting an output that cannot load simply wait in their FIFO.
    always_comb begin
        logic [2:0] cand;
        cand    = '0;
        grant_v = '0;
        pop     = uturn;
        for (int unsigned q = 0; q < NUM_PORTS; q++) begin
            grant_idx[q] = '0;
            if (load_en[q]) begin
                for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                    cand = rr_index(rr_ptr[q], k);
                    if (!grant_v[q] && !empty[cand] && !uturn[cand] && route[cand] == port_e'(q)) begin
                        grant_v[q]   = 1'b1;
                        grant_idx[q] = cand;
                    end
                end
            end
            if (grant_v[q]) pop[grant_idx[q]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid     <= '0;
            o_data      <= '0;
            o_route_err <= 1'b0;
            for (int unsigned q = 0; q < NUM_PORTS; q++) rr_ptr[q] <= '0;
        end else begin
            if (|uturn) o_route_err <= 1'b1;
            for (int unsigned q = 0; q < NUM_PORTS; q++) begin
                if (load_en[q]) begin
                    o_valid[q] <= grant_v[q];
                    if (grant_v[q]) begin
                        o_data[q*TOTAL_WIDTH +: TOTAL_WIDTH] <= head[grant_idx[q]];
                        rr_ptr[q] <= rr_index(grant_idx[q], 1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_router_buffered.sv
// Bench for noc_router_buffered at (1,1): directed vectors plus random traffic
// compared every cycle against a queue-based reference model.
module tb_noc_router_buffered;

    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    i_valid;
    logic [4:0]    o_ready;
    logic [5*TW-1:0] i_data;
    logic [4:0]    o_valid;
    logic [4:0]    i_ready;
    logic [5*TW-1:0] o_data;
    logic          o_route_err;

    always #5 clk = ~clk;

    noc_router_buffered #(
        .X_COORD    (1),
        .Y_COORD    (1),
        .X_SIZE     (2),
        .Y_SIZE     (2),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_route_err (o_route_err)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: one queue per input, one register per output.
    logic [15:0] mq [5][$];
    logic [4:0]  m_ov;
    logic [15:0] m_od [5];
    int          m_ptr [5];
    logic        m_err;

    typedef struct {
        int          port;
        logic [15:0] pkt;
        int          exp_port;   // -1: dropped as U-turn
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mroute(input logic [15:0] pk);
        int dx = int'(pk[3:2]);
        int dy = int'(pk[1:0]);
        if (dx > 1) return 2;
        if (dx < 1) return 4;
        if (dy > 1) return 1;
        if (dy < 1) return 3;
        return 0;
    endfunction

    task automatic model_step();
        logic [4:0] popm;
        logic [4:0] pushm;
        if (rst) begin
            for (int p = 0; p < 5; p++) begin
                mq[p].delete();
                m_od[p]  = '0;
                m_ptr[p] = 0;
            end
            m_ov  = '0;
            m_err = 1'b0;
            return;
        end
        popm = '0;
        for (int p = 0; p < 5; p++) pushm[p] = i_valid[p] && (mq[p].size() < 4);
        for (int q = 0; q < 5; q++) begin
            if (!m_ov[q] || i_ready[q]) begin
                bit found = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    int p = (m_ptr[q] + k) % 5;
                    if (!found && mq[p].size() > 0 && mroute(mq[p][0]) == q && !(p != 0 && p == q)) begin
                        found    = 1'b1;
                        m_od[q]  = mq[p][0];
                        popm[p]  = 1'b1;
                        m_ptr[q] = (p + 1) % 5;
                    end
                end
                m_ov[q] = found;
            end
        end
        for (int p = 1; p < 5; p++) begin
            if (mq[p].size() > 0 && mroute(mq[p][0]) == p) begin
                popm[p] = 1'b1;
                m_err   = 1'b1;
            end
        end
        for (int p = 0; p < 5; p++) begin
            if (popm[p])  void'(mq[p].pop_front());
            if (pushm[p]) mq[p].push_back(i_data[p*TW +: TW]);
        end
    endtask

    task automatic check_outputs();
        logic [4:0] exp_rdy;
        for (int p = 0; p < 5; p++) exp_rdy[p] = !rst && (mq[p].size() < 4);
        chk("o_valid", 32'(o_valid), 32'(m_ov));
        chk("o_ready", 32'(o_ready), 32'(exp_rdy));
        chk("o_route_err", 32'(o_route_err), 32'(m_err));
        for (int q = 0; q < 5; q++)
            if (m_ov[q]) chk($sformatf("o_data[%0d]", q), 32'(o_data[q*TW +: TW]), 32'(m_od[q]));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(input int p, input logic [15:0] pk);
        i_valid[p] = 1'b1;
        i_data[p*TW +: TW] = pk;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [4:0]  ev;
        logic [15:0] exp_n [4];
        int          acc;
        int          k;
        bit          will;

        rst     = 1'b1;
        i_valid = '0;
        i_data  = '0;
        i_ready = '1;
        #1;
        tick();
        chk("reset_o_data", 32'(o_data == '0), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_release", 32'(o_ready), 32'h1f);

        tbl[0] = '{4, 16'hA505, 0};
        tbl[1] = '{0, 16'h3C09, 2};
        tbl[2] = '{0, 16'h5506, 1};
        tbl[3] = '{0, 16'h6604, 3};
        tbl[4] = '{1, 16'h4401, 4};
        tbl[5] = '{3, 16'h8805, 0};
        tbl[6] = '{2, 16'h7709, -1};
        tbl[7] = '{1, 16'h9906, -1};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].port, tbl[i].pkt);
            tick();
            i_valid = '0;
            tick();
            ev = '0;
            if (tbl[i].exp_port >= 0) ev[tbl[i].exp_port] = 1'b1;
            chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(ev));
            if (tbl[i].exp_port >= 0)
                chk($sformatf("vec%0d_data", i), 32'(o_data[tbl[i].exp_port*TW +: TW]), 32'(tbl[i].pkt));
            tick();
            chk($sformatf("vec%0d_one_cycle", i), 32'(o_valid), 32'h0);
            if (tbl[i].exp_port < 0) chk($sformatf("vec%0d_err", i), 32'(o_route_err), 32'd1);
        end

        // Contention for N: PE wins the tie, then W drains in order.
        do_reset();
        tick();
        exp_n = '{16'h2206, 16'h1106, 16'h1106, 16'h3306};
        drive(0, 16'h2206);
        drive(4, 16'h1106);
        tick();
        i_valid = '0;
        drive(4, 16'h1106);
        tick();
        chk("cont0_valid", 32'(o_valid), 32'h02);
        chk("cont0_data", 32'(o_data[1*TW +: TW]), 32'(exp_n[0]));
        i_valid = '0;
        tick();
        chk("cont1_valid", 32'(o_valid), 32'h02);
        chk("cont1_data", 32'(o_data[1*TW +: TW]), 32'(exp_n[1]));
        drive(0, 16'h3306);
        tick();
        chk("cont2_data", 32'(o_data[1*TW +: TW]), 32'(exp_n[2]));
        i_valid = '0;
        tick();
        chk("cont3_data", 32'(o_data[1*TW +: TW]), 32'(exp_n[3]));
        tick();

        // Backpressure on E: 1 in the output register + 4 queued.
        i_ready[2] = 1'b0;
        acc = 0;
        k   = 0;
        for (int c = 0; c < 12; c++) begin
            if (k < 8) drive(4, 16'h0009 | (16'(k) << 8));
            else       i_valid = '0;
            will = o_ready[4] && (k < 8);
            tick();
            if (will) begin
                acc++;
                k++;
            end
        end
        chk("bp_accepted", 32'(acc), 32'd5);
        chk("bp_ready_low", 32'(o_ready[4]), 32'd0);
        chk("bp_hold_valid", 32'(o_valid[2]), 32'd1);
        chk("bp_hold_data", 32'(o_data[2*TW +: TW]), 32'h0009);
        i_valid = '0;
        i_ready[2] = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk($sformatf("bp_drain%0d", j), 32'(o_data[2*TW +: TW]), 32'(16'h0009 | (16'(j) << 8)));
        end
        tick();
        chk("bp_drained", 32'(o_valid[2]), 32'd0);

        // Mid-run reset with packets buffered and the error flag set.
        i_ready[2] = 1'b0;
        drive(2, 16'h7709);
        tick();
        i_valid = '0;
        for (int j = 1; j <= 3; j++) begin
            drive(0, 16'hB009 | (16'(j) << 8));
            tick();
        end
        i_valid = '0;
        tick();
        chk("pre_reset_err", 32'(o_route_err), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_err", 32'(o_route_err), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'h0);
        chk("rst_data", 32'(o_data == '0), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(o_ready), 32'h1f);
        i_ready = '1;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("post_rst_quiet", 32'(o_valid), 32'h0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            rst     = ($urandom % 64) == 0;
            i_valid = 5'($urandom);
            i_ready = 5'($urandom | $urandom);
            for (int p = 0; p < 5; p++) i_data[p*TW +: TW] = 16'($urandom);
            tick();
        end
        rst     = 1'b0;
        i_valid = '0;
        i_ready = '1;
        for (int c = 0; c < 20; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
